// File: rtl/puf_resp_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : puf_resp_engine
// Description : Drives one challenge to a bank of arbiter PUF chains, fires the
//               race VOTE_CNT times (relax/fire half-phases of SETTLE_CYC
//               cycles each), majority-votes every chain and reports the voted
//               bits, per-chain stability and a saturating instability count.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_resp_engine #(
  parameter int CHAL_W     = 128,
  parameter int N_CHAINS   = 4,
  parameter int VOTE_CNT   = 5,
  parameter int SETTLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                chal_valid,
  output logic                chal_ready,
  input  logic [CHAL_W-1:0]   chal_in,
  output logic [CHAL_W-1:0]   puf_chal,
  output logic                puf_launch,
  input  logic [N_CHAINS-1:0] puf_resp,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [N_CHAINS-1:0] resp_bits,
  output logic [N_CHAINS-1:0] resp_stable,
  output logic [15:0]         unstable_total,
  output logic                busy
);

  localparam int CW = $clog2(VOTE_CNT + 1);
  localparam int PW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TRIAL_LAST = CW'(VOTE_CNT - 1);
  localparam logic [CW-1:0] VOTE_MAX   = CW'(VOTE_CNT);
  localparam logic [CW-1:0] VOTE_HALF  = CW'(VOTE_CNT / 2);

  // Parameter sanity: an even trial count has no majority, zero-length phases
  // would never let the arbiters settle.
  if ((VOTE_CNT < 1) || ((VOTE_CNT % 2) == 0)) begin : g_bad_vote_cnt
    $error("puf_resp_engine: VOTE_CNT must be odd and >= 1");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle_cyc
    $error("puf_resp_engine: SETTLE_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RELAX = 2'd1,
    S_FIRE  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   phase;
  logic [CW-1:0]   trial;
  logic [CW-1:0]   ones_cnt [N_CHAINS];

  logic [N_CHAINS-1:0] vote_bits;
  logic [N_CHAINS-1:0] vote_stable;
  logic [15:0]         unstable_cnt;
  logic [16:0]         total_sum;
  logic [15:0]         total_next;

  // Majority vote, stability flags and saturating update of the unstable count.
  always_comb begin
    vote_bits    = '0;
    vote_stable  = '0;
    unstable_cnt = '0;
    for (int i = 0; i < N_CHAINS; i++) begin
      vote_bits[i]   = (ones_cnt[i] > VOTE_HALF);
      vote_stable[i] = (ones_cnt[i] == '0) || (ones_cnt[i] == VOTE_MAX);
      unstable_cnt   = unstable_cnt + {15'd0, ~vote_stable[i]};
    end
    total_sum  = {1'b0, unstable_total} + {1'b0, unstable_cnt};
    total_next = total_sum[16] ? 16'hFFFF : total_sum[15:0];
  end

  // Control FSM; every output is registered so puf_launch cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      chal_ready     <= 1'b1;
      puf_chal       <= '0;
      puf_launch     <= 1'b0;
      resp_valid     <= 1'b0;
      resp_bits      <= '0;
      resp_stable    <= '0;
      unstable_total <= '0;
      busy           <= 1'b0;
      phase          <= '0;
      trial          <= '0;
      for (int i = 0; i < N_CHAINS; i++) ones_cnt[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (chal_valid && chal_ready) begin
            puf_chal   <= chal_in;
            phase      <= '0;
            trial      <= '0;
            for (int i = 0; i < N_CHAINS; i++) ones_cnt[i] <= '0;
            chal_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= S_RELAX;
          end else begin
            // Re-opens the input one cycle after a result handshake.
            chal_ready <= 1'b1;
          end
        end
        S_RELAX: begin
          if (phase == PHASE_LAST) begin
            phase      <= '0;
            puf_launch <= 1'b1;
            state      <= S_FIRE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        S_FIRE: begin
          if (phase == PHASE_LAST) begin
            for (int i = 0; i < N_CHAINS; i++)
              ones_cnt[i] <= ones_cnt[i] + CW'(puf_resp[i]);
            phase      <= '0;
            puf_launch <= 1'b0;
            trial      <= trial + CW'(1);
            state      <= (trial == TRIAL_LAST) ? S_DONE : S_RELAX;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the result (once); later cycles wait.
          if (!resp_valid) begin
            resp_valid     <= 1'b1;
            resp_bits      <= vote_bits;
            resp_stable    <= vote_stable;
            unstable_total <= total_next;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_puf_resp_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_puf_resp_engine
// Description : Directed self-checking bench for puf_resp_engine with a
//               scoreboard of expected voted results (default, minimal and
//               saturation-oriented parameter sets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_resp_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Default-parameter instance
  logic         chal_valid, chal_ready, puf_launch, resp_valid, resp_ready, busy;
  logic [127:0] chal_in, puf_chal;
  logic [3:0]   puf_resp, resp_bits, resp_stable;
  logic [15:0]  unstable_total;

  // Minimal instance: one chain, one trial, one-cycle phases
  logic         t_valid, t_ready, t_launch, t_rvalid, t_rready, t_busy;
  logic [7:0]   t_chal_in, t_chal;
  logic [0:0]   t_resp, t_bits, t_stable;
  logic [15:0]  t_total;

  // Saturation instance: 16 chains, 3 trials, one-cycle phases
  logic         s_valid, s_ready, s_launch, s_rvalid, s_rready, s_busy;
  logic [7:0]   s_chal_in, s_chal;
  logic [15:0]  s_resp, s_bits, s_stable;
  logic [15:0]  s_total;

  puf_resp_engine dut (
    .clk(clk), .rst_n(rst_n), .chal_valid(chal_valid), .chal_ready(chal_ready),
    .chal_in(chal_in), .puf_chal(puf_chal), .puf_launch(puf_launch),
    .puf_resp(puf_resp), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_bits(resp_bits), .resp_stable(resp_stable),
    .unstable_total(unstable_total), .busy(busy)
  );

  puf_resp_engine #(.CHAL_W(8), .N_CHAINS(1), .VOTE_CNT(1), .SETTLE_CYC(1)) dut_min (
    .clk(clk), .rst_n(rst_n), .chal_valid(t_valid), .chal_ready(t_ready),
    .chal_in(t_chal_in), .puf_chal(t_chal), .puf_launch(t_launch),
    .puf_resp(t_resp), .resp_valid(t_rvalid), .resp_ready(t_rready),
    .resp_bits(t_bits), .resp_stable(t_stable),
    .unstable_total(t_total), .busy(t_busy)
  );

  puf_resp_engine #(.CHAL_W(8), .N_CHAINS(16), .VOTE_CNT(3), .SETTLE_CYC(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .chal_valid(s_valid), .chal_ready(s_ready),
    .chal_in(s_chal_in), .puf_chal(s_chal), .puf_launch(s_launch),
    .puf_resp(s_resp), .resp_valid(s_rvalid), .resp_ready(s_rready),
    .resp_bits(s_bits), .resp_stable(s_stable),
    .unstable_total(s_total), .busy(s_busy)
  );

  // Per-trial response table for the default instance; the trial index
  // advances each time the launch line drops after a fire phase.
  logic [3:0] pat [5];
  int falls = 0;
  int base  = 0;
  int idx;
  always @(negedge puf_launch) falls <= falls + 1;
  always_comb begin
    idx      = falls - base;
    puf_resp = (idx >= 0 && idx < 5) ? pat[idx[2:0]] : 4'b0000;
  end

  // Saturation instance: alternating response per trial, never unanimous.
  logic [15:0] s_fc = '0;
  int s_runs = 0;
  always @(posedge clk) if (s_launch) s_fc <= s_fc + 16'd1;
  always @(posedge clk) if (s_rvalid && s_rready) s_runs <= s_runs + 1;
  assign s_resp = {16{s_fc[0]}};

  typedef struct packed {
    logic [3:0]  bits;
    logic [3:0]  stable;
    logic [15:0] total;
  } exp_t;
  exp_t sb[$];
  logic [15:0] exp_total = '0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference majority vote over the current pattern table.
  task automatic push_expect();
    exp_t e;
    int unst = 0;
    int sum;
    for (int c = 0; c < 4; c++) begin
      int cnt = 0;
      for (int t = 0; t < 5; t++) cnt += int'(pat[t][c]);
      e.bits[c]   = (cnt >= 3);
      e.stable[c] = (cnt == 0 || cnt == 5);
      if (!e.stable[c]) unst++;
    end
    sum = int'(exp_total) + unst;
    exp_total = (sum > 65535) ? 16'hFFFF : 16'(sum);
    e.total = exp_total;
    sb.push_back(e);
  endtask

  // Offer a challenge, measure latency to resp_valid and score the result.
  task automatic run_chal(input logic [127:0] ch, input string tag);
    int lat;
    exp_t e;
    chk({tag, "_ready"}, chal_ready, 1'b1);
    chal_in = ch;
    chal_valid = 1'b1;
    base = falls;
    push_expect();
    @(posedge clk); #1;
    chal_valid = 1'b0;
    chk({tag, "_chal"}, puf_chal, ch);
    lat = 0;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 41);
    e = sb.pop_front();
    chk({tag, "_bits"}, resp_bits, e.bits);
    chk({tag, "_stable"}, resp_stable, e.stable);
    chk({tag, "_total"}, unstable_total, e.total);
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_hs_valid_low"}, {resp_valid, chal_ready}, 2'b00);
    @(posedge clk); #1;
    chk({tag, "_hs_ready_back"}, {chal_ready, busy}, 2'b10);
  endtask

  initial begin
    int lat;
    int vr;
    rst_n = 1'b1;
    chal_valid = 0; chal_in = '0; resp_ready = 0;
    t_valid = 0; t_chal_in = 8'h5A; t_rready = 0; t_resp = 1'b0;
    s_valid = 0; s_chal_in = 8'hC3; s_rready = 0;
    for (int t = 0; t < 5; t++) pat[t] = 4'b0000;

    // T1: reset asserted mid-clock
    #3 rst_n = 1'b0;
    #1;
    chk("t1_ready", chal_ready, 1'b1);
    chk("t1_outs", {puf_launch, resp_valid, busy, resp_bits, resp_stable}, 11'd0);
    chk("t1_total", unstable_total, 16'd0);
    chk("t1_chal", puf_chal, 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T2: stable responses
    for (int t = 0; t < 5; t++) pat[t] = 4'b1010;
    run_chal(128'hc71f2e46cc9dc3bfdd47048bc4bdce79, "t2");
    handshake("t2");
    chk("t2_retained", {resp_bits, resp_stable}, 8'b1010_1111);

    // T3: noisy chains 0 and 1
    pat[0] = 4'b0001; pat[1] = 4'b0000; pat[2] = 4'b0011;
    pat[3] = 4'b0000; pat[4] = 4'b0001;
    run_chal(128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978, "t3");

    // T4: backpressure; a challenge offered meanwhile must be ignored
    chal_in = 128'hdead_beef; chal_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("t4_hold", {resp_valid, chal_ready, resp_bits, resp_stable}, 10'b1_0_0001_1100);
    end
    chal_valid = 1'b0;
    chk("t4_chal_kept", puf_chal, 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978);
    handshake("t4");

    // T5: reset 20 cycles into a challenge
    for (int t = 0; t < 5; t++) pat[t] = 4'b1010;
    chal_in = 128'h1111_2222; chal_valid = 1'b1;
    @(posedge clk); #1;
    chal_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_launch_pre", puf_launch, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_launch_rst", {puf_launch, resp_valid, busy, chal_ready}, 4'b0001);
    chk("t5_total_rst", unstable_total, 16'd0);
    exp_total = '0;
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    vr = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (resp_valid) vr++;
    end
    chk("t5_no_valid", vr, 0);
    run_chal(128'hfeed_face_cafe, "t5");
    handshake("t5");

    // T6: minimal parameters, 3-edge latency, always stable
    for (int r = 0; r < 2; r++) begin
      t_resp = (r == 0) ? 1'b1 : 1'b0;
      t_valid = 1'b1;
      @(posedge clk); #1;
      t_valid = 1'b0;
      lat = 0;
      while (!t_rvalid && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("t6_latency", lat, 3);
      chk("t6_result", {t_bits, t_stable, t_total}, {t_resp, 1'b1, 16'd0});
      t_rready = 1'b1;
      @(posedge clk); #1;
      t_rready = 1'b0;
      @(posedge clk); #1;
    end

    // Saturation of unstable_total: 16 unstable chains per run
    s_valid = 1'b1; s_rready = 1'b1;
    lat = 0;
    while (s_runs < 4095 && lat < 60000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("sat_4095_runs", s_runs, 4095);
    chk("sat_pre_total", s_total, 16'hFFF0);
    chk("sat_stable", s_stable, 16'h0000);
    lat = 0;
    while (s_runs < 4097 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("sat_4097_runs", s_runs, 4097);
    chk("sat_total", s_total, 16'hFFFF);
    s_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
